// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the MEM-stage data memory access block
package mem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam logic [1:0] COND_FLUSH = 2'd0;
   localparam logic [1:0] COND_RUN   = 2'd1;
   localparam logic [1:0] COND_HOLD  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Size code 3 behaves as a word access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      case (size)
         SIZE_BYTE: is_misaligned = 1'b0;
         SIZE_HALF: is_misaligned = offset[0];
         default:   is_misaligned = (offset != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data memory bus between the MEM stage and the memory
interface mem_access_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/mem_lane_fmt.sv
// rtl/mem_lane_fmt.sv - byte enables, store lane replication and load extraction
module mem_lane_fmt
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        is_signed,
   input  logic [31:0] store_data,
   input  logic [31:0] load_raw,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);
   logic [31:0] shifted;

   always_comb begin
      shifted   = load_raw >> {offset, 3'b000};
      be        = 4'b1111;
      wdata     = store_data;
      load_data = load_raw;
      case (size)
         SIZE_BYTE: begin
            be        = 4'b0001 << offset;
            wdata     = {4{store_data[7:0]}};
            load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
         end
         SIZE_HALF: begin
            be        = 4'b0011 << {offset[1], 1'b0};
            wdata     = {2{store_data[15:0]}};
            load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM-stage load/store sequencer with pipeline stall and bus timeout
module mem_access
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                EXMEM_MemRead,
   input  logic                EXMEM_MemWrite,
   input  logic [1:0]          EXMEM_MemSize,
   input  logic                EXMEM_MemSigned,
   input  logic [31:0]         EXMEM_ALUOut,
   input  logic [31:0]         EXMEM_WriteData,
   mem_access_if.master        dmem,
   output logic [31:0]         MEM_ReadData,
   output logic                stall_req,
   output logic [1:0]          memwb_condition,
   output logic                misalign,
   output logic                bus_err
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_e           state, state_nxt;
   logic [CNT_W-1:0] tmo_cnt;
   logic [31:0]      addr_q, wdata_q, rdata_q;
   logic [3:0]       be_q;
   logic             we_q, misalign_q, bus_err_q;
   logic             access, bad_align, start, fault_now, tmo_hit;
   logic [3:0]       fmt_be;
   logic [31:0]      fmt_wdata, fmt_rdata;

   assign access    = EXMEM_MemRead | EXMEM_MemWrite;
   assign bad_align = is_misaligned(EXMEM_MemSize, EXMEM_ALUOut[1:0]);
   assign start     = (state == ST_IDLE) && access && !bad_align;
   assign fault_now = (state == ST_IDLE) && access && bad_align;
   assign tmo_hit   = (state == ST_REQ) && !dmem.dmem_ack
                      && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // EXMEM is frozen by stall_req throughout REQ, so its size/offset also format the returning data.
   mem_lane_fmt u_fmt (
      .size       (EXMEM_MemSize),
      .offset     (EXMEM_ALUOut[1:0]),
      .is_signed  (EXMEM_MemSigned),
      .store_data (EXMEM_WriteData),
      .load_raw   (dmem.dmem_rdata),
      .be         (fmt_be),
      .wdata      (fmt_wdata),
      .load_data  (fmt_rdata)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_REQ;
         ST_REQ:  if (dmem.dmem_ack || tmo_hit) state_nxt = ST_DONE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         tmo_cnt    <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         be_q       <= '0;
         we_q       <= 1'b0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state      <= state_nxt;
         misalign_q <= fault_now;
         bus_err_q  <= tmo_hit;
         if (start) begin
            addr_q  <= {EXMEM_ALUOut[31:2], 2'b00};
            we_q    <= EXMEM_MemWrite;
            be_q    <= fmt_be;
            wdata_q <= fmt_wdata;
            tmo_cnt <= '0;
         end else if (state == ST_REQ) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
         end
         if (state == ST_REQ && dmem.dmem_ack) rdata_q <= fmt_rdata;
         else if (tmo_hit)                     rdata_q <= '0;
      end
   end

   assign dmem.dmem_req   = (state == ST_REQ);
   assign dmem.dmem_we    = we_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_wdata = wdata_q;
   assign dmem.dmem_be    = be_q;

   assign stall_req       = start || (state == ST_REQ);
   assign memwb_condition = (stall_req || fault_now) ? COND_FLUSH : COND_RUN;
   assign MEM_ReadData    = (state == ST_DONE && !we_q) ? rdata_q : 32'd0;
   assign misalign        = misalign_q;
   assign bus_err         = bus_err_q;
endmodule
